scan_digit_mux: RTL
===================

Name: scan_digit_mux

Overview:
- Upstream driver for the seven-segment decoder in the traffic-controller display path.
- Holds NDIG packed BCD digits and time-multiplexes them onto one 4-bit BCD bus that feeds the decoder.
- Drives active-low digit-select lines for the common-anode display.
- Digit updates from the countdown logic are double-buffered and committed only at frame boundaries, so a frame never mixes old and new digits.

Parameters:
- NDIG, 4, number of display digits; digit 0 is least significant at DIG_IN[3:0]; legal range 2..8.
- SCAN_DIV, 50000, CLK cycles each digit is shown; legal range >= 1.
- CNT_W, 16, prescaler width; must satisfy 2^CNT_W >= SCAN_DIV.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  synchronous reset, active-high.
- DIG_IN  in  4*NDIG  packed BCD digits; digit k is DIG_IN[4k+3:4k].
- LOAD  in  1  single-cycle strobe; DIG_IN is sampled in this cycle.
- BLANK  in  1  level input; forces all digits off.
- BCD_OUT  out  4  BCD value for the decoder input.
- AN_OUT  out  NDIG  active-low digit select; bit k enables digit k.
- LOAD_ACK  out  1  one-cycle pulse when the staged digits are committed to the display.
- FRAME_END  out  1  one-cycle pulse on the scan tick that wraps the digit index to 0.

Behaviour:
- Reset values (RST high at a clock edge): prescaler=0, idx=0, staging=0, shadow=0, pending=0, BCD_OUT=0, AN_OUT=all ones, LOAD_ACK=0, FRAME_END=0. RST overrides everything, including a LOAD in the same cycle, and aborts any pending commit.
- Prescaler: counts 0..SCAN_DIV-1 and wraps to 0. tick is asserted in the cycle the count equals SCAN_DIV-1. With SCAN_DIV=1, tick is asserted every cycle.
- Digit index idx: advances on tick and wraps from NDIG-1 to 0.
- Frame boundary: a tick in a cycle where idx==NDIG-1. FRAME_END is registered and is high in the cycle after the boundary.
- LOAD when not at a frame boundary: staging<=DIG_IN and pending<=1. A further LOAD while pending overwrites staging (latest wins); only one ACK results.
- Commit: at a frame boundary with pending=1 or LOAD=1, shadow is written and pending<=0.
  - If LOAD is high in that cycle, shadow<=DIG_IN directly (the new data bypasses staging).
  - Otherwise shadow<=staging.
  - LOAD_ACK goes high in the next cycle, coincident with FRAME_END.
- Frame boundary with no pending and no LOAD: shadow unchanged, no ACK.
- Outputs (registered, one-cycle latency from idx):
  - BCD_OUT <= shadow digit[idx], where idx and shadow are the values after this cycle's update.
  - AN_OUT <= ~(1<<idx).
  - After the cycle in which RST deasserts, AN_OUT=~1 and BCD_OUT=shadow[0].
- BLANK=1: AN_OUT<=all ones. BCD_OUT, the prescaler and idx keep running, so scan phase is preserved. Release resumes on the current idx the next cycle.
- Non-BCD digits (values 10..15) pass through unmodified; the decoder handles them.
- Exactly one AN_OUT bit is low at any time outside blank and reset.

Optional Feature:
- Macro: SCAN_LZB_EN (leading-zero blanking).
- Defined: when digit k>0 and every shadow digit from k through NDIG-1 is 0, AN_OUT bit k stays high during its slot. Digit 0 is never blanked by this rule. Slot timing is unchanged.
- Undefined: all digits are displayed, including leading zeros.

Test Plan (NDIG=4, SCAN_DIV=4 unless stated):
- Reset then free-run: AN_OUT sequence is E,D,B,7, each value held 4 cycles, repeating. BCD_OUT=0 throughout. FRAME_END pulses every 16 cycles.
- LOAD with DIG_IN=16'h1234 mid-frame: the current frame continues showing 0. LOAD_ACK and FRAME_END pulse together. The next frame shows BCD 4,3,2,1 on AN E,D,B,7.
- LOAD 16'h1111 then LOAD 16'h5678 within the same frame: exactly one LOAD_ACK. The next frame displays 8,7,6,5.
- LOAD 16'h9999 in the exact frame-boundary cycle: LOAD_ACK next cycle. The following slot shows BCD 9 on AN=E.
- BLANK held 6 cycles mid-slot: AN_OUT=F during the hold. On release, the slot timing shows no drift versus an unblanked reference count. RST mid-frame returns AN=F and BCD=0 the next cycle.
- SCAN_LZB_EN defined, shadow=16'h0042: AN_OUT sequence is E,D,F,F. SCAN_DIV=1: idx advances every cycle.

Source files
------------

// File: rtl/scan_digit_mux.sv
// Time-multiplexed BCD digit driver for a common-anode seven-segment display.
// Define SCAN_LZB_EN to blank leading zeros (digit 0 is always shown).
module scan_digit_mux #(
  parameter int unsigned NDIG     = 4,
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [4*NDIG-1:0] DIG_IN,
  input  logic              LOAD,
  input  logic              BLANK,
  output logic [3:0]        BCD_OUT,
  output logic [NDIG-1:0]   AN_OUT,
  output logic              LOAD_ACK,
  output logic              FRAME_END
);

  localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned DW    = 4 * NDIG;

  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [DW-1:0]    staging, staging_n;
  logic [DW-1:0]    shadow, shadow_n;
  logic             pending, pending_n;
  logic             tick, boundary, commit;
  logic [3:0]       bcd_n;
  logic [NDIG-1:0]  an_n;

  assign tick     = (cnt == CNT_W'(SCAN_DIV - 1));
  assign boundary = tick && (idx == IDX_W'(NDIG - 1));
  assign commit   = boundary && (pending || LOAD);

  // Scan timing and double-buffered digit update
  always_comb begin
    cnt_n     = cnt + CNT_W'(1);
    idx_n     = idx;
    staging_n = staging;
    shadow_n  = shadow;
    pending_n = pending;
    if (tick) begin
      cnt_n = '0;
      idx_n = (idx == IDX_W'(NDIG - 1)) ? '0 : idx + IDX_W'(1);
    end
    if (boundary) begin
      pending_n = 1'b0;
      if (LOAD) begin
        shadow_n = DIG_IN;
      end else if (pending) begin
        shadow_n = staging;
      end
    end else if (LOAD) begin
      staging_n = DIG_IN;
      pending_n = 1'b1;
    end
  end

`ifdef SCAN_LZB_EN
  logic [NDIG-1:0] lz;
  logic            zero_run;

  // lz[k] is set when digit k and every digit above it are zero
  always_comb begin
    lz       = '0;
    zero_run = 1'b1;
    for (int k = NDIG - 1; k >= 1; k--) begin
      zero_run = zero_run && (shadow_n[4*k +: 4] == 4'd0);
      lz[k]    = zero_run;
    end
  end
`endif

  // Digit value and active-low select for the slot following this cycle
  always_comb begin
    bcd_n = '0;
    an_n  = '1;
    for (int k = 0; k < NDIG; k++) begin
      if (idx_n == IDX_W'(k)) begin
        bcd_n = shadow_n[4*k +: 4];
`ifdef SCAN_LZB_EN
        an_n[k] = lz[k];
`else
        an_n[k] = 1'b0;
`endif
      end
    end
    if (BLANK) begin
      an_n = '1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt       <= '0;
      idx       <= '0;
      staging   <= '0;
      shadow    <= '0;
      pending   <= 1'b0;
      BCD_OUT   <= '0;
      AN_OUT    <= '1;
      LOAD_ACK  <= 1'b0;
      FRAME_END <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      idx       <= idx_n;
      staging   <= staging_n;
      shadow    <= shadow_n;
      pending   <= pending_n;
      BCD_OUT   <= bcd_n;
      AN_OUT    <= an_n;
      LOAD_ACK  <= commit;
      FRAME_END <= boundary;
    end
  end

endmodule
